// File: rtl/psg_register_file.sv
// SN76489-style PSG write port: latch/data byte decoding, sound register
// storage and the READY busy window that follows every accepted write.
module psg_register_file #(
    parameter int WRITE_CYCLES = 32,
    parameter int CONTROL_BITS = 4,
    parameter int TONE_BITS    = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [7:0]              data,
    output logic                    ready,
    output logic [TONE_BITS-1:0]    tone0,
    output logic [TONE_BITS-1:0]    tone1,
    output logic [TONE_BITS-1:0]    tone2,
    output logic [2:0]              noise_control,
    output logic                    noise_reset,
    output logic [CONTROL_BITS-1:0] attenuation0,
    output logic [CONTROL_BITS-1:0] attenuation1,
    output logic [CONTROL_BITS-1:0] attenuation2,
    output logic [CONTROL_BITS-1:0] attenuation3
);

    localparam int CW = (WRITE_CYCLES > 0) ? $clog2(WRITE_CYCLES + 1) : 1;

    logic [1:0]              r_ch;
    logic                    r_type;
    logic [CW-1:0]           r_cnt;
    logic                    r_ready;
    logic [TONE_BITS-1:0]    r_tone [3];
    logic [CONTROL_BITS-1:0] r_att  [4];
    logic [2:0]              r_noise;
    logic                    r_nrst;

    logic       w_accept;
    logic       w_latch;
    logic [1:0] w_ch;
    logic       w_type;

    assign w_accept = wr_en & r_ready;
    assign w_latch  = data[7];
    // A latch byte retargets immediately, so its low nibble goes to the new register
    assign w_ch     = w_latch ? data[6:5] : r_ch;
    assign w_type   = w_latch ? data[4]   : r_type;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch    <= 2'd0;
            r_type  <= 1'b0;
            r_noise <= 3'd0;
            r_nrst  <= 1'b0;
            for (int i = 0; i < 3; i++) r_tone[i] <= '0;
            for (int i = 0; i < 4; i++) r_att[i]  <= '1;
        end else begin
            r_nrst <= 1'b0;
            if (w_accept) begin
                if (w_latch) begin
                    r_ch   <= data[6:5];
                    r_type <= data[4];
                end
                if (w_type) begin
                    r_att[w_ch] <= CONTROL_BITS'(data[3:0]);
                end else if (w_ch == 2'd3) begin
                    r_noise <= data[2:0];
                    r_nrst  <= 1'b1;
                end else if (w_latch) begin
                    r_tone[w_ch][3:0] <= data[3:0];
                end else begin
                    r_tone[w_ch][TONE_BITS-1:4] <= (TONE_BITS-4)'(data[5:0]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_ready <= 1'b1;
        end else if (w_accept && WRITE_CYCLES > 0) begin
            r_cnt   <= CW'(WRITE_CYCLES);
            r_ready <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt - CW'(1);
            r_ready <= (r_cnt == CW'(1));
        end
    end

    assign ready         = r_ready;
    assign tone0         = r_tone[0];
    assign tone1         = r_tone[1];
    assign tone2         = r_tone[2];
    assign noise_control = r_noise;
    assign noise_reset   = r_nrst;
    assign attenuation0  = r_att[0];
    assign attenuation1  = r_att[1];
    assign attenuation2  = r_att[2];
    assign attenuation3  = r_att[3];

endmodule

// File: tb/tb_psg_register_file.sv
// Scoreboard bench for psg_register_file: stimulus queues expected values,
// a negedge monitor pops and compares them against the live outputs.
module tb_psg_register_file;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready;
    logic [9:0] tone0, tone1, tone2;
    logic [2:0] noise_control;
    logic       noise_reset;
    logic [3:0] attenuation0, attenuation1, attenuation2, attenuation3;

    psg_register_file #(
        .WRITE_CYCLES(32),
        .CONTROL_BITS(4),
        .TONE_BITS(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .data(data),
        .ready(ready),
        .tone0(tone0),
        .tone1(tone1),
        .tone2(tone2),
        .noise_control(noise_control),
        .noise_reset(noise_reset),
        .attenuation0(attenuation0),
        .attenuation1(attenuation1),
        .attenuation2(attenuation2),
        .attenuation3(attenuation3)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    sel;
        int    v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    localparam int T0 = 0, T1 = 1, T2 = 2, NC = 3, NR = 4;
    localparam int A0 = 5, A1 = 6, A2 = 7, A3 = 8, RDY = 9;

    function automatic int get(int sel);
        case (sel)
            T0:      return int'(tone0);
            T1:      return int'(tone1);
            T2:      return int'(tone2);
            NC:      return int'(noise_control);
            NR:      return int'(noise_reset);
            A0:      return int'(attenuation0);
            A1:      return int'(attenuation1);
            A2:      return int'(attenuation2);
            A3:      return int'(attenuation3);
            default: return int'(ready);
        endcase
    endfunction

    task automatic expect_v(input string name, input int sel, input int v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.v    = v;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            int   got;
            e   = q.pop_front();
            got = get(e.sel);
            checks++;
            if (got == e.v) passes++;
            else $display("FAIL %s: got %0h want %0h", e.name, got, e.v);
        end
    end

    // Called at posedge+1; waits (bounded) for ready, then issues one write.
    task automatic wr(input logic [7:0] d);
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) expect_v("ready_timeout", RDY, 1);
        wr_en = 1'b1;
        data  = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) expect_v("ready_timeout", RDY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ev;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // 1: reset state
        expect_v("rst_ready", RDY, 1);
        expect_v("rst_tone0", T0, 0);
        expect_v("rst_tone1", T1, 0);
        expect_v("rst_tone2", T2, 0);
        expect_v("rst_att0", A0, 15);
        expect_v("rst_att1", A1, 15);
        expect_v("rst_att2", A2, 15);
        expect_v("rst_att3", A3, 15);
        expect_v("rst_nc", NC, 0);
        expect_v("rst_nr", NR, 0);

        // 2: tone latch + data
        wr(8'h8E);
        expect_v("tone0_lo", T0, 'h00E);
        expect_v("busy_after_wr", RDY, 0);
        wr(8'h0F);
        expect_v("tone0_full", T0, 'h0FE);

        // 3: attenuation latch + data
        wr(8'hD5);
        expect_v("att2_latch", A2, 5);
        wr(8'h0A);
        expect_v("att2_data", A2, 'hA);
        expect_v("att2_t0", T0, 'h0FE);
        expect_v("att2_t1", T1, 0);
        expect_v("att2_a0", A0, 15);
        expect_v("att2_a1", A1, 15);
        expect_v("att2_a3", A3, 15);
        expect_v("att2_nc", NC, 0);

        // 4: noise register and reset pulse
        wr(8'hE6);
        expect_v("nc_latch", NC, 6);
        expect_v("nr_pulse1", NR, 1);
        @(posedge clk);
        #1;
        expect_v("nr_end1", NR, 0);
        wr(8'h03);
        expect_v("nc_data", NC, 3);
        expect_v("nr_pulse2", NR, 1);
        @(posedge clk);
        #1;
        expect_v("nr_end2", NR, 0);

        // 5: wr_en held high, data toggling; only ready-window edges accept
        wait_ready();
        wr_en = 1'b1;
        for (int a = 0; a < 4; a++) begin
            data = (a % 2 == 0) ? 8'h9F : 8'h90;
            ev   = (a % 2 == 0) ? 4'hF : 4'h0;
            @(posedge clk);
            #1;
            expect_v("hold_acc_att0", A0, int'(ev));
            expect_v("hold_acc_rdy", RDY, 0);
            data = (a % 2 == 0) ? 8'h90 : 8'h9F;
            for (int k = 1; k <= 32; k++) begin
                @(posedge clk);
                #1;
                expect_v("hold_rdy", RDY, (k == 32) ? 1 : 0);
                expect_v("hold_att0", A0, int'(ev));
            end
        end
        wr_en = 1'b0;

        // 6: async reset inside a busy window
        wr(8'h8A);
        expect_v("t6_lo", T0, 'h0FA);
        wr(8'h3F);
        expect_v("t6_full", T0, 'h3FA);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_v("arst_ready", RDY, 1);
        expect_v("arst_tone0", T0, 0);
        expect_v("arst_att2", A2, 15);
        expect_v("arst_nc", NC, 0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr(8'h05);
        expect_v("post_rst_data", T0, 'h050);
        expect_v("post_rst_att0", A0, 15);

        @(negedge clk);
        #1;
        if (q.size() != 0) $display("FAIL drain: got %0d want 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
